// File: rtl/gate3_truth_sequencer_pkg.sv
// Shared types and constants for the 3-input gate truth-table sequencer.
package gate3_seq_pkg;

    // Controller states: wait for a run, hold a vector, capture it, report
    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    // One input vector per row of a 3-input truth table
    localparam int NUM_VEC = 8;

    // Index of the final vector; the sweep stops here instead of wrapping
    localparam logic [2:0] LAST_IDX = 3'(NUM_VEC - 1);

    // Reference truth tables, bit i = Z for {A,B,C} = i
    localparam logic [7:0] TT_AND3  = 8'h80;
    localparam logic [7:0] TT_OR3   = 8'hFE;
    localparam logic [7:0] TT_NAND3 = 8'h7F;
    localparam logic [7:0] TT_NOR3  = 8'h01;

endpackage

// File: rtl/gate3_truth_sequencer_if.sv
// Control/status and gate-under-test connections of the truth sequencer.
// The master side is the controlling bench or FSM plus the gate it wraps;
// the slave side is the sequencer itself.
interface gate3_truth_sequencer_if;
    import gate3_seq_pkg::*;

    logic                 start;
    logic                 abort;
    logic [NUM_VEC-1:0]   exp_tt;
    logic                 gut_z;
    logic                 gut_a;
    logic                 gut_b;
    logic                 gut_c;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [NUM_VEC-1:0]   result_tt;
    logic [3:0]           mismatch_cnt;
    logic [2:0]           first_err_idx;

    modport master (
        output start, abort, exp_tt, gut_z,
        input  gut_a, gut_b, gut_c, busy, done, pass,
               result_tt, mismatch_cnt, first_err_idx
    );

    modport slave (
        input  start, abort, exp_tt, gut_z,
        output gut_a, gut_b, gut_c, busy, done, pass,
               result_tt, mismatch_cnt, first_err_idx
    );

endinterface

// File: rtl/gate3_truth_sequencer_settle_timer.sv
// Settle-time counter: counts enabled cycles from zero and flags the last
// cycle of the settle window so the controller can move on to sampling.
module settle_timer #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [7:0] LAST_COUNT = 8'(SETTLE_CYCLES - 1);

    logic [7:0] count;

    // Clear has priority so a new vector always starts its window at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 8'd0;
        end else if (clr) begin
            count <= 8'd0;
        end else if (en) begin
            count <= count + 8'd1;
        end
    end

    assign tc = (count == LAST_COUNT);

endmodule

// File: rtl/gate3_truth_sequencer.sv
// Drives all eight input vectors of a 3-input gate in ascending order,
// samples its output after a settle window and compares the measured truth
// table against the table latched when the sweep was started.
module gate3_truth_sequencer
    import gate3_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    gate3_truth_sequencer_if.slave   seq
);

    state_t      state;
    state_t      state_nxt;
    logic        timer_clr;
    logic        timer_en;
    logic        timer_tc;
    logic        load_start;
    logic        do_sample;
    logic        do_abort;

    logic [7:0]  exp_latched;
    logic [2:0]  idx;
    logic [2:0]  vec;
    logic [7:0]  result_q;
    logic [3:0]  mm_cnt;
    logic [2:0]  first_err;
    logic        pass_q;

    logic        z_one;
    logic        z_known;
    logic        z_mismatch;

    settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (timer_clr),
        .en  (timer_en),
        .tc  (timer_tc)
    );

    // An undriven or unknown gate output never counts as a correct answer
    assign z_one      = (seq.gut_z === 1'b1);
    assign z_known    = (seq.gut_z === 1'b0) || z_one;
    assign z_mismatch = !z_known || (z_one != exp_latched[idx]);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-cycle control strobes; abort beats every other event
    always_comb begin
        state_nxt  = state;
        timer_clr  = 1'b0;
        timer_en   = 1'b0;
        load_start = 1'b0;
        do_sample  = 1'b0;
        do_abort   = 1'b0;
        case (state)
            IDLE: begin
                if (seq.start && !seq.abort) begin
                    state_nxt  = SETTLE;
                    timer_clr  = 1'b1;
                    load_start = 1'b1;
                end
            end
            SETTLE: begin
                if (seq.abort) begin
                    state_nxt = IDLE;
                    timer_clr = 1'b1;
                    do_abort  = 1'b1;
                end else if (timer_tc) begin
                    state_nxt = SAMPLE;
                    timer_clr = 1'b1;
                end else begin
                    timer_en  = 1'b1;
                end
            end
            SAMPLE: begin
                if (seq.abort) begin
                    state_nxt = IDLE;
                    do_abort  = 1'b1;
                end else begin
                    do_sample = 1'b1;
                    state_nxt = (idx == LAST_IDX) ? DONE : SETTLE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                do_abort  = seq.abort;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Sweep datapath: vector register, measured table and error bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_latched <= 8'd0;
            idx         <= 3'd0;
            vec         <= 3'd0;
            result_q    <= 8'd0;
            mm_cnt      <= 4'd0;
            first_err   <= 3'd0;
            pass_q      <= 1'b0;
        end else begin
            if (load_start) begin
                exp_latched <= seq.exp_tt;
                idx         <= 3'd0;
                vec         <= 3'd0;
                result_q    <= 8'd0;
                mm_cnt      <= 4'd0;
                first_err   <= 3'd0;
                pass_q      <= 1'b0;
            end
            if (do_abort) begin
                vec    <= 3'd0;
                pass_q <= 1'b0;
            end
            if (do_sample) begin
                result_q[idx] <= z_one;
                if (z_mismatch) begin
                    mm_cnt <= mm_cnt + 4'd1;
                    if (mm_cnt == 4'd0) begin
                        first_err <= idx;
                    end
                end
                if (idx == LAST_IDX) begin
                    pass_q <= (mm_cnt == 4'd0) && !z_mismatch;
                end else begin
                    idx <= idx + 3'd1;
                    vec <= idx + 3'd1;
                end
            end
        end
    end

    assign seq.gut_a         = vec[2];
    assign seq.gut_b         = vec[1];
    assign seq.gut_c         = vec[0];
    assign seq.busy          = (state != IDLE);
    assign seq.done          = (state == DONE) && !seq.abort;
    assign seq.pass          = pass_q;
    assign seq.result_tt     = result_q;
    assign seq.mismatch_cnt  = mm_cnt;
    assign seq.first_err_idx = first_err;

endmodule

// File: tb/tb_gate3_truth_sequencer.sv
// Bench for the 3-input gate truth sequencer. The gate under test is modelled
// as a truth table so AND, OR, stuck-at and random gates share one model.
module tb_gate3_truth_sequencer;
    import gate3_seq_pkg::*;

    localparam int SC = 4;
    localparam int HOLD = SC + 1;
    localparam int SWEEP = NUM_VEC * HOLD;

    logic       clk;
    logic       rst;
    logic [7:0] gut_tt;
    int         total;
    int         bad;

    gate3_truth_sequencer_if bus();

    gate3_truth_sequencer #(
        .SETTLE_CYCLES (SC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .seq (bus)
    );

    assign bus.gut_z = gut_tt[{bus.gut_a, bus.gut_b, bus.gut_c}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: number of rows where the measured and expected tables differ
    function automatic int popcount8(input logic [7:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) n += int'(v[i]);
        return n;
    endfunction

    // Reference: lowest differing row, 0 when the tables agree
    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return 3'(i);
        return 3'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete sweep, checking vector timing every cycle and the report
    // afterwards; restart_at >= 0 pulses a stray start at that cycle.
    task automatic run_full_sweep(input string name, input logic [7:0] g,
                                  input logic [7:0] e, input int restart_at);
        logic [7:0] diff;
        logic [2:0] exp_vec;
        int         v;
        diff       = g ^ e;
        gut_tt     = g;
        bus.exp_tt = e;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        bus.exp_tt = 8'($urandom);
        for (int j = 0; j <= SWEEP; j++) begin
            v       = (j / HOLD > 7) ? 7 : j / HOLD;
            exp_vec = 3'(v);
            total++;
            if ({bus.gut_a, bus.gut_b, bus.gut_c} !== exp_vec) begin
                bad++;
                $display("[TB] FAIL %s vec@%0d: got %0d expected %0d", name, j,
                         {bus.gut_a, bus.gut_b, bus.gut_c}, exp_vec);
            end
            total++;
            if (bus.busy !== 1'b1) begin
                bad++;
                $display("[TB] FAIL %s busy@%0d: got %b expected 1", name, j, bus.busy);
            end
            total++;
            if (bus.done !== (j == SWEEP)) begin
                bad++;
                $display("[TB] FAIL %s done@%0d: got %b expected %b", name, j,
                         bus.done, (j == SWEEP));
            end
            bus.start = (j == restart_at) ? 1'b1 : 1'b0;
            tick();
        end
        bus.start = 1'b0;
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s idle_after: busy=%b done=%b expected 0 0", name,
                     bus.busy, bus.done);
        end
        total++;
        if ({bus.gut_a, bus.gut_b, bus.gut_c} !== 3'b111) begin
            bad++;
            $display("[TB] FAIL %s vec_hold: got %0d expected 7", name,
                     {bus.gut_a, bus.gut_b, bus.gut_c});
        end
        total++;
        if (bus.result_tt !== g) begin
            bad++;
            $display("[TB] FAIL %s result_tt: got %h expected %h", name, bus.result_tt, g);
        end
        total++;
        if (bus.mismatch_cnt !== 4'(popcount8(diff))) begin
            bad++;
            $display("[TB] FAIL %s mismatch_cnt: got %0d expected %0d", name,
                     bus.mismatch_cnt, popcount8(diff));
        end
        total++;
        if (bus.first_err_idx !== lowest_set(diff)) begin
            bad++;
            $display("[TB] FAIL %s first_err_idx: got %0d expected %0d", name,
                     bus.first_err_idx, lowest_set(diff));
        end
        total++;
        if (bus.pass !== (diff == 8'd0)) begin
            bad++;
            $display("[TB] FAIL %s pass: got %b expected %b", name, bus.pass, (diff == 8'd0));
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.abort  = 1'b0;
        bus.exp_tt = 8'd0;
        gut_tt     = 8'd0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        total++;
        if ({bus.gut_a, bus.gut_b, bus.gut_c, bus.busy, bus.done, bus.pass} !== 6'd0) begin
            bad++;
            $display("[TB] FAIL reset_ctrl: got %b expected 000000",
                     {bus.gut_a, bus.gut_b, bus.gut_c, bus.busy, bus.done, bus.pass});
        end
        total++;
        if ({bus.result_tt, bus.mismatch_cnt, bus.first_err_idx} !== 15'd0) begin
            bad++;
            $display("[TB] FAIL reset_status: got %h/%0d/%0d expected 0/0/0",
                     bus.result_tt, bus.mismatch_cnt, bus.first_err_idx);
        end
    endtask

    task automatic test_and();
        run_full_sweep("and3", TT_AND3, TT_AND3, -1);
    endtask

    task automatic test_or();
        run_full_sweep("or3", TT_OR3, TT_OR3, -1);
        run_full_sweep("or3_vs_and", TT_OR3, TT_AND3, -1);
    endtask

    task automatic test_stuck();
        run_full_sweep("stuck0", 8'h00, TT_OR3, -1);
        run_full_sweep("nand_vs_nor", TT_NAND3, TT_NOR3, -1);
    endtask

    task automatic test_back_to_back();
        run_full_sweep("restart_ignored", TT_AND3, TT_AND3, 2);
        run_full_sweep("back_to_back", TT_NOR3, TT_NOR3, -1);
    endtask

    task automatic test_abort();
        logic [7:0] g;
        logic [7:0] e;
        logic [7:0] diff;
        g          = 8'($urandom);
        e          = 8'($urandom);
        diff       = (g ^ e) & 8'h07;
        gut_tt     = g;
        bus.exp_tt = e;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int j = 0; j < 4 * HOLD; j++) begin
            total++;
            if ({bus.gut_a, bus.gut_b, bus.gut_c} !== 3'(j / HOLD)) begin
                bad++;
                $display("[TB] FAIL abort_vec@%0d: got %0d expected %0d", j,
                         {bus.gut_a, bus.gut_b, bus.gut_c}, j / HOLD);
            end
            if (j == 4 * HOLD - 1) bus.abort = 1'b1;
            tick();
        end
        bus.abort = 1'b0;
        total++;
        if ({bus.gut_a, bus.gut_b, bus.gut_c, bus.busy, bus.done, bus.pass} !== 6'd0) begin
            bad++;
            $display("[TB] FAIL abort_ctrl: got %b expected 000000",
                     {bus.gut_a, bus.gut_b, bus.gut_c, bus.busy, bus.done, bus.pass});
        end
        total++;
        if (bus.result_tt !== (g & 8'h07)) begin
            bad++;
            $display("[TB] FAIL abort_result: got %h expected %h", bus.result_tt, g & 8'h07);
        end
        total++;
        if (bus.mismatch_cnt !== 4'(popcount8(diff)) || bus.first_err_idx !== lowest_set(diff)) begin
            bad++;
            $display("[TB] FAIL abort_errs: got %0d/%0d expected %0d/%0d", bus.mismatch_cnt,
                     bus.first_err_idx, popcount8(diff), lowest_set(diff));
        end
        for (int j = 0; j < SWEEP + 4; j++) begin
            total++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                bad++;
                $display("[TB] FAIL abort_quiet@%0d: done=%b busy=%b expected 0 0", j,
                         bus.done, bus.busy);
            end
            tick();
        end
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        for (int j = 0; j < 3; j++) begin
            total++;
            if (bus.busy !== 1'b0 || bus.result_tt !== (g & 8'h07)) begin
                bad++;
                $display("[TB] FAIL start_abort@%0d: busy=%b result=%h expected 0 %h", j,
                         bus.busy, bus.result_tt, g & 8'h07);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        gut_tt     = TT_OR3;
        bus.exp_tt = TT_AND3;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (2 * HOLD + 1) tick();
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({bus.gut_a, bus.gut_b, bus.gut_c, bus.busy, bus.done, bus.pass} !== 6'd0) begin
            bad++;
            $display("[TB] FAIL async_rst_ctrl: got %b expected 000000",
                     {bus.gut_a, bus.gut_b, bus.gut_c, bus.busy, bus.done, bus.pass});
        end
        total++;
        if ({bus.result_tt, bus.mismatch_cnt, bus.first_err_idx} !== 15'd0) begin
            bad++;
            $display("[TB] FAIL async_rst_status: got %h/%0d/%0d expected 0/0/0",
                     bus.result_tt, bus.mismatch_cnt, bus.first_err_idx);
        end
        #1;
        rst = 1'b0;
        tick();
        run_full_sweep("after_reset", TT_AND3, TT_AND3, -1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            run_full_sweep($sformatf("rand%0d", k), 8'($urandom), 8'($urandom),
                           int'($urandom_range(0, SWEEP - 1)));
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_and();
        test_or();
        test_stuck();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guards against the run stalling on a broken design
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] run exceeded time limit");
    end

endmodule
